// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, rcon table, GF(2^8) helpers,
// column mixing functions and state/word byte-index helpers.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYPRE,
        ST_LOAD,
        ST_ROUND,
        ST_DONE
    } aes_state_e;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    // Round constant for key-expansion step idx (0..9)
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = '0;
        aa = a;
        bb = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0 as AES requires)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [31:0] mixcol32(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] invmixcol32(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // Byte idx = 4*column + row; byte 0 lives in bits [127:120]
    function automatic logic [7:0] state_byte(input logic [127:0] s, input logic [3:0] idx);
        return s[127 - 8*idx -: 8];
    endfunction

    function automatic logic [31:0] state_word(input logic [127:0] s, input logic [1:0] col);
        return s[127 - 32*col -: 32];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// 8-bit AES S-box, forward or inverse selected by inv_i,
// built from the GF(2^8) inverse plus the affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic       inv_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    logic [7:0] pre;
    logic [7:0] inv_val;

    // Inverse affine ahead of the field inverse, forward affine after it
    always_comb begin
        pre = data_i;
        if (inv_i) begin
            pre = {data_i[6:0], data_i[7]} ^ {data_i[4:0], data_i[7:5]}
                ^ {data_i[1:0], data_i[7:2]} ^ 8'h05;
        end
        inv_val = gf_inv(pre);
        data_o  = inv_val;
        if (!inv_i) begin
            data_o = inv_val ^ {inv_val[6:0], inv_val[7]} ^ {inv_val[5:0], inv_val[7:6]}
                   ^ {inv_val[4:0], inv_val[7:5]} ^ {inv_val[3:0], inv_val[7:4]} ^ 8'h63;
        end
    end

endmodule

// File: rtl/aes_core_compact_v3.sv
// Iterative AES-128 encrypt/decrypt core: one 32-bit column per cycle,
// four shared S-boxes, round keys expanded on the fly.
module aes_core_compact_v3
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         enc_dec,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic [127:0] data_out,
    output logic         ready
);

    aes_state_e   fsm_q;
    logic [127:0] data_q;
    logic [127:0] key_q;
    logic [127:0] state_q;
    logic [127:0] buf_q;
    logic [127:0] data_out_q;
    logic         enc_q;
    logic         ready_q;
    logic [3:0]   round_q;
    logic [2:0]   step_q;

    logic [7:0]   sb_in  [4];
    logic [7:0]   sb_out [4];
    logic         sb_inv;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  sub_w;
    logic [31:0]  t_w;
    logic [31:0]  kw_src;
    logic [31:0]  rk_w;
    logic [31:0]  x_w;
    logic [31:0]  n0, n1, n2, n3;
    logic [31:0]  col_d;
    logic [127:0] key_d;
    logic [127:0] buf_d;
    logic [127:0] commit_d;
    logic [1:0]   col_idx;
    logic [1:0]   src;
    logic [3:0]   rc_idx;
    logic         key_step;
    logic         inv_key;
    logic         last_round;

    assign {w0, w1, w2, w3} = key_q;
    assign col_idx    = step_q[1:0] - 2'd1;
    assign key_step   = (fsm_q == ST_KEYPRE) || (fsm_q == ST_ROUND && step_q == 3'd0);
    assign inv_key    = (fsm_q == ST_ROUND) && !enc_q;
    assign last_round = (round_q == LAST_ROUND);

    // S-box operand select: key word in key steps, ShiftRows diagonal otherwise
    always_comb begin
        sb_inv = 1'b0;
        src    = '0;
        kw_src = inv_key ? (w3 ^ w2) : w3;
        for (int unsigned r = 0; r < 4; r++) sb_in[r] = '0;
        if (key_step) begin
            sb_in[0] = kw_src[23:16];
            sb_in[1] = kw_src[15:8];
            sb_in[2] = kw_src[7:0];
            sb_in[3] = kw_src[31:24];
        end else if (fsm_q == ST_ROUND) begin
            sb_inv = !enc_q;
            for (int unsigned r = 0; r < 4; r++) begin
                src      = enc_q ? (col_idx + 2'(r)) : (col_idx - 2'(r));
                sb_in[r] = state_byte(state_q, {src, 2'(r)});
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .inv_i  (sb_inv),
            .data_i (sb_in[g]),
            .data_o (sb_out[g])
        );
    end

    // Key schedule step (forward or inverse) and column result
    always_comb begin
        sub_w  = {sb_out[0], sb_out[1], sb_out[2], sb_out[3]};
        rc_idx = inv_key ? (LAST_ROUND - round_q) : (round_q - 4'd1);
        t_w    = sub_w ^ {rcon(rc_idx), 24'h0};
        n0     = w0 ^ t_w;
        n1     = w1 ^ n0;
        n2     = w2 ^ n1;
        n3     = w3 ^ n2;
        if (inv_key) begin
            // Walk back one round key: w3 depends only on w2/w3, w0 needs the S-box
            key_d = {w0 ^ t_w, w1 ^ w0, w2 ^ w1, w3 ^ w2};
        end else begin
            key_d = {n0, n1, n2, n3};
        end

        rk_w = state_word(key_q, col_idx);
        x_w  = sub_w ^ rk_w;
        if (enc_q) begin
            col_d = (last_round ? sub_w : mixcol32(sub_w)) ^ rk_w;
        end else begin
            col_d = last_round ? x_w : invmixcol32(x_w);
        end

        buf_d = buf_q;
        case (col_idx)
            2'd0:    buf_d[127:96] = col_d;
            2'd1:    buf_d[95:64]  = col_d;
            2'd2:    buf_d[63:32]  = col_d;
            default: buf_d[31:0]   = col_d;
        endcase
        commit_d = {buf_q[127:32], col_d};
    end

    // Control FSM with all datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q      <= ST_IDLE;
            data_q     <= '0;
            key_q      <= '0;
            state_q    <= '0;
            buf_q      <= '0;
            data_out_q <= '0;
            enc_q      <= 1'b0;
            ready_q    <= 1'b1;
            round_q    <= '0;
            step_q     <= '0;
        end else begin
            case (fsm_q)
                ST_IDLE, ST_DONE: begin
                    fsm_q <= ST_IDLE;
                    if (start) begin
                        data_q  <= data_in;
                        key_q   <= key_in;
                        enc_q   <= enc_dec;
                        round_q <= 4'd1;
                        step_q  <= '0;
                        ready_q <= 1'b0;
                        fsm_q   <= enc_dec ? ST_LOAD : ST_KEYPRE;
                    end
                end
                ST_KEYPRE: begin
                    key_q <= key_d;
                    if (last_round) begin
                        round_q <= 4'd1;
                        fsm_q   <= ST_LOAD;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                ST_LOAD: begin
                    state_q <= data_q ^ key_q;
                    step_q  <= '0;
                    fsm_q   <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (step_q == 3'd0) begin
                        key_q <= key_d;
                    end else begin
                        buf_q <= buf_d;
                    end
                    if (step_q == 3'd4) begin
                        step_q  <= '0;
                        state_q <= commit_d;
                        if (last_round) begin
                            data_out_q <= commit_d;
                            ready_q    <= 1'b1;
                            fsm_q      <= ST_DONE;
                        end else begin
                            round_q <= round_q + 4'd1;
                        end
                    end else begin
                        step_q <= step_q + 3'd1;
                    end
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

    assign data_out = data_out_q;
    assign ready    = ready_q;

endmodule

// File: tb/tb_aes_core_compact_v3.sv
// Directed-vector bench for aes_core_compact_v3 (FIPS-197 vectors,
// latency, back-to-back, busy-time input changes, mid-run reset).
module tb_aes_core_compact_v3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         enc_dec;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic [127:0] data_out;
    logic         ready;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    always #5 clk = ~clk;

    aes_core_compact_v3 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .enc_dec  (enc_dec),
        .data_in  (data_in),
        .key_in   (key_in),
        .data_out (data_out),
        .ready    (ready)
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for ready; lat counts edges after the start edge
    task automatic run_op(input logic enc, input logic [127:0] d, input logic [127:0] k,
                          input logic disturb, output logic [127:0] res, output int lat);
        @(negedge clk);
        start   = 1'b1;
        enc_dec = enc;
        data_in = d;
        key_in  = k;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        check("busy_after_start", 128'(ready), 128'(0));
        while (!ready && lat < 200) begin
            if (disturb && lat == 10) begin
                start   = 1'b1;
                enc_dec = ~enc;
                data_in = ~d;
                key_in  = ~k;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        res   = data_out;
    endtask

    initial begin
        logic [127:0] res;
        int           lat;

        rst     = 1'b1;
        start   = 1'b0;
        enc_dec = 1'b0;
        data_in = '0;
        key_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 128'(ready), 128'(1));
        check("reset_data_out", data_out, '0);
        @(negedge clk);
        rst = 1'b0;

        run_op(1'b1, PT_C1, K_C1, 1'b0, res, lat);
        check("c1_enc", res, CT_C1);
        check("c1_enc_lat", 128'(lat), 128'(51));
        repeat (3) @(posedge clk);
        #1;
        check("hold_data_out", data_out, CT_C1);
        check("hold_ready", 128'(ready), 128'(1));

        run_op(1'b0, CT_C1, K_C1, 1'b0, res, lat);
        check("c1_dec", res, PT_C1);
        check("c1_dec_lat", 128'(lat), 128'(61));

        run_op(1'b1, PT_B, K_B, 1'b0, res, lat);
        check("b_enc", res, CT_B);
        check("b_enc_lat", 128'(lat), 128'(51));

        run_op(1'b1, '0, '0, 1'b0, res, lat);
        check("zero_enc", res, CT_Z);

        run_op(1'b0, CT_Z, '0, 1'b0, res, lat);
        check("zero_dec", res, '0);
        check("zero_dec_lat", 128'(lat), 128'(61));

        run_op(1'b1, PT_C1, K_C1, 1'b1, res, lat);
        check("disturb_enc", res, CT_C1);
        check("disturb_lat", 128'(lat), 128'(51));

        // Abort a run part-way through round processing
        @(negedge clk);
        start   = 1'b1;
        enc_dec = 1'b1;
        data_in = PT_B;
        key_in  = K_B;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mid_busy", 128'(ready), 128'(0));
        rst = 1'b1;
        #1;
        check("abort_ready", 128'(ready), 128'(1));
        check("abort_data_out", data_out, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_abort_data_out", data_out, '0);

        run_op(1'b1, PT_C1, K_C1, 1'b0, res, lat);
        check("post_abort_enc", res, CT_C1);
        check("post_abort_lat", 128'(lat), 128'(51));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
